// File: rtl/skew_delay_line.sv
// Per-lane programmable delay line: CHANNELS lanes of {vld, data}, each delayed 1..MAX_DELAY edges.
// Output is a register mux (no din->dout path); no backpressure, a global enable freezes every lane.
module skew_delay_line #(
   parameter int WIDTH       = 8,
   parameter int CHANNELS    = 2,
   parameter int MAX_DELAY   = 8,
   parameter int RESET_DELAY = 1,
   parameter int CNT_W       = 16,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int DW         = $clog2(MAX_DELAY + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic [CHANNELS-1:0]       din_vld,
   input  logic                      cfg_we,
   input  logic [CH_W-1:0]           cfg_ch,
   input  logic [DW-1:0]             cfg_delay,
   output logic [CHANNELS*WIDTH-1:0] dout,
   output logic [CHANNELS-1:0]       dout_vld,
   output logic [CHANNELS*CNT_W-1:0] cnt,
   output logic                      cfg_err
);

   localparam int IW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

   logic [WIDTH-1:0]     stage_dat [CHANNELS][MAX_DELAY];
   logic [MAX_DELAY-1:0] stage_vld [CHANNELS];
   logic [DW-1:0]        delay     [CHANNELS];
   logic [CNT_W-1:0]     cnt_q     [CHANNELS];
   logic [IW-1:0]        sel       [CHANNELS];
   logic [DW-1:0]        delay_m1  [CHANNELS];
   logic                 cfg_ok;
   logic [CHANNELS-1:0]  flush;

   // Operands widened by one bit so the range checks never collapse to constants.
   always_comb begin
      cfg_ok = cfg_we
               && (cfg_delay != '0)
               && ({1'b0, cfg_delay} <= (DW + 1)'(MAX_DELAY))
               && ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
      flush = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         flush[c] = cfg_ok && (cfg_ch == CH_W'(c));
      end
   end

   always_comb begin
      dout     = '0;
      dout_vld = '0;
      cnt      = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         delay_m1[c] = delay[c] - DW'(1);
         sel[c]      = delay_m1[c][IW-1:0];
         dout[c*WIDTH +: WIDTH] = stage_dat[c][sel[c]];
         dout_vld[c]            = stage_vld[c][sel[c]];
         cnt[c*CNT_W +: CNT_W]  = cnt_q[c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
               stage_dat[c][k] <= '0;
            end
            stage_vld[c] <= '0;
            delay[c]     <= DW'(RESET_DELAY);
            cnt_q[c]     <= '0;
         end
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         for (int c = 0; c < CHANNELS; c++) begin
            // Data keeps shifting through a flush; only the valid tags are cleared.
            if (en) begin
               stage_dat[c][0] <= din[c*WIDTH +: WIDTH];
               for (int k = 1; k < MAX_DELAY; k++) begin
                  stage_dat[c][k] <= stage_dat[c][k-1];
               end
            end
            if (flush[c]) begin
               stage_vld[c] <= '0;
               delay[c]     <= cfg_delay;
            end else if (en) begin
               stage_vld[c][0] <= din_vld[c];
               for (int k = 1; k < MAX_DELAY; k++) begin
                  stage_vld[c][k] <= stage_vld[c][k-1];
               end
               if (dout_vld[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
                  cnt_q[c] <= cnt_q[c] + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule
